// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//
// This is the multi-cycle control FSM for a simple load/store core. It
// sequences instruction fetch, decode, execute, data memory access and
// register writeback. It also keeps a retired-instruction counter, a bounded
// wait on memory acknowledges, and sticky halt and bus-error status.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          leave IDLE and begin fetching
//   opcode         IR[31:26] from the decoder; held stable from DECODE to WB
//   ins_zero       current IR is all zeros (NOP)
//   alu_zero       ALU zero flag, used by BEQ in EXEC
//   imem_ack       instruction memory data valid
//   dmem_ack       data memory access complete
//   imem_req       instruction fetch request (every FETCH cycle)
//   ir_load        load IR from imem (same cycle as imem_ack)
//   pc_inc         PC <= PC+4 (same cycle as imem_ack)
//   pc_branch      PC <= branch target (BEQ taken, EXEC)
//   alu_src_imm    ALU B operand is the sign-extended immediate
//   dmem_req       data memory request (every MEM cycle)
//   dmem_we        data memory write enable (stores)
//   reg_write      register file write enable (WB)
//   mem_to_reg     writeback data comes from memory (loads)
//   halted         sticky: HALT opcode executed
//   bus_error      sticky: a memory ack did not arrive within TIMEOUT cycles
//   retired        retired-instruction count, wraps modulo 2^CNT_W
//   state          current state encoding
module multicycle_control_unit #(
  parameter logic [5:0] OP_LW   = 6'b010011,
  parameter logic [5:0] OP_SW   = 6'b010100,
  parameter logic [5:0] OP_BEQ  = 6'b010101,
  parameter logic [5:0] OP_HALT = 6'b111111,
  parameter int         TIMEOUT = 16,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             ins_zero,
  input  logic             alu_zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             alu_src_imm,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  // The wait counter only has to hold 0..TIMEOUT-1.
  localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               wait_inc;

  logic is_lw, is_sw, is_beq;
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);

  // Next-state, retire and wait-counter control.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    wait_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (imem_ack)                state_d  = S_DECODE;
        else if (wait_q == WAIT_LAST) state_d  = S_ERROR;
        else                          wait_inc = 1'b1;
      end
      S_DECODE: begin
        if (ins_zero) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // The counter only runs while waiting; any state change clears it,
    // which covers entry into FETCH and MEM.
    wait_d    = wait_inc ? (wait_q + WAIT_W'(1)) : '0;
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Outputs decode from the state register. ir_load/pc_inc follow imem_ack
  // in the same cycle, so the outputs drop as soon as reset forces IDLE.
  always_comb begin
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    alu_src_imm = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    bus_error   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        pc_inc   = imem_ack;
      end
      S_EXEC: begin
        alu_src_imm = opcode[4];
        pc_branch   = is_beq & alu_zero;
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        alu_src_imm = 1'b1;
        dmem_we     = is_sw;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
      end
      S_HALT:  halted    = 1'b1;
      S_ERROR: bus_error = 1'b1;
      default: ;
    endcase
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM that sequences the instruction register, the instruction decoder, the ALU, the register file and the memories.
- Consumes the decoded opcode fields and the ALU zero flag. Drives the per-cycle enables and the instruction/data memory request handshakes.
- Provides a retired-instruction counter, a bounded memory-wait timeout and sticky halt/error status.

Parameters:
- OP_LW, 6'b010011, load-word opcode (I-type, bit4=1)
- OP_SW, 6'b010100, store-word opcode (I-type)
- OP_BEQ, 6'b010101, branch-if-equal opcode (I-type)
- OP_HALT, 6'b111111, halt opcode
- TIMEOUT, 16, max cycles waiting for any memory ack (>=2)
- CNT_W, 16, retired-counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE and begin fetching
- opcode  in  6  opcode field from the instruction decoder (IR[31:26])
- ins_zero  in  1  current IR is all zeros (NOP)
- alu_zero  in  1  ALU zero flag
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load IR from imem
- pc_inc  out  1  PC <= PC+4
- pc_branch  out  1  PC <= branch target
- alu_src_imm  out  1  ALU B operand = sign-extended imm
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback data from memory
- halted  out  1  sticky halt status
- bus_error  out  1  sticky timeout status
- retired  out  CNT_W  retired-instruction count
- state  out  3  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Reset is asynchronous and immediate. On reset: state=IDLE, retired=0, wait counter=0, all outputs 0. Any outstanding request drops the same instant.
- IDLE: all outputs 0. Goes to FETCH on the cycle after start=1 is sampled.
- FETCH:
  - imem_req=1 for every FETCH cycle.
  - When imem_ack=1: ir_load=1 and pc_inc=1 in that same cycle (Mealy), then go to DECODE.
- DECODE: exactly one cycle.
  - ins_zero=1: retired+1, go to FETCH.
  - else opcode==OP_HALT: go to HALT (halt is not counted).
  - else go to EXEC.
- EXEC: exactly one cycle; alu_src_imm=opcode[4].
  - OP_BEQ: pc_branch=alu_zero, retired+1, go to FETCH.
  - OP_LW / OP_SW: go to MEM.
  - Any other opcode: go to WB.
- MEM:
  - dmem_req=1 and alu_src_imm=1 throughout; dmem_we=1 only for OP_SW.
  - On dmem_ack=1: OP_SW does retired+1 and goes to FETCH; OP_LW goes to WB.
- WB: exactly one cycle.
  - reg_write=1; mem_to_reg=1 only if opcode==OP_LW.
  - retired+1, go to FETCH.
- Latencies with zero-wait acks: R-type = 4 cycles; BEQ = 3; SW = 4; LW = 5.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle without the relevant ack.
  - If it reaches TIMEOUT-1 with no ack, go to ERROR next cycle.
  - An ack in that same cycle wins (no error).
- HALT: halted=1. ERROR: bus_error=1. Both hold all other outputs 0 and stay until reset; start is ignored.
- Stray acks: an imem_ack outside FETCH or a dmem_ack outside MEM has no effect.
- opcode is sampled combinationally; it must be stable from DECODE through WB (the IR does not change outside ir_load).
- retired wraps modulo 2^CNT_W.
- Exactly one of pc_inc/pc_branch is asserted in any cycle, or neither.

Test Plan:
- R-type: reset, start, imem_ack immediate, opcode=6'b000000, ins_zero=0 -> states 1,2,3,5. reg_write=1 for one cycle, mem_to_reg=0, retired=1.
- LW then SW with dmem_ack delayed 3 cycles:
  - LW: dmem_req high 4 cycles, dmem_we=0, WB has mem_to_reg=1.
  - SW: dmem_we=1, no WB, retired=2.
- BEQ: with alu_zero=1, pc_branch pulses once in EXEC. With alu_zero=0, no pc_branch. Both go to FETCH next cycle.
- Timeout: TIMEOUT=16, imem_ack never -> ERROR after 16 FETCH cycles, bus_error=1 sticky, imem_req=0. Ack on cycle 16 instead -> DECODE, no error.
- HALT opcode -> halted=1, retired unchanged. start pulses ignored. A rst_n pulse returns state=0 and halted=0.
- Async reset asserted mid-MEM with dmem_req=1 -> dmem_req=0 before the next clk edge, retired=0. Wrap check: CNT_W=4 and 16 NOPs -> retired=0.
